// File: rtl/timer_device_pkg.sv
// Shared constants for the timer I/O device: bus width, register addresses and
// the bit positions inside the control/status register.
package timer_device_pkg;

  localparam int unsigned TIMER_DBITS = 32;

  localparam logic [31:0] TIMER_ADDR_TCNT = 32'hF000_0020;
  localparam logic [31:0] TIMER_ADDR_TLIM = 32'hF000_0024;
  localparam logic [31:0] TIMER_ADDR_TCTL = 32'hF000_0120;

  localparam int unsigned TCTL_READY_BIT = 0;
  localparam int unsigned TCTL_OVR_BIT   = 2;
  localparam int unsigned TCTL_IE_BIT    = 8;

endpackage

// File: rtl/timer_device_tick_gen.sv
// Prescaler: counts 0..PRESCALE-1 and pulses tick_o for the single cycle spent
// at PRESCALE-1. A synchronous clear takes priority over counting.
module timer_device_tick_gen #(
  parameter int unsigned PRESCALE = 50000
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  output logic tick_o
);

  localparam int unsigned CntW = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(PRESCALE - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  assign tick_o = (cnt_q == CntMax);

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i || tick_o) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/timer_device.sv
// Memory-mapped interval timer: millisecond counter with optional wrap limit,
// sticky READY/OVR flags, interrupt enable and a tri-state read port on DBUS.
module timer_device
  import timer_device_pkg::*;
#(
  parameter int unsigned DBITS     = TIMER_DBITS,
  parameter int unsigned PRESCALE  = 50000,
  parameter logic [31:0] ADDR_TCNT = TIMER_ADDR_TCNT,
  parameter logic [31:0] ADDR_TLIM = TIMER_ADDR_TLIM,
  parameter logic [31:0] ADDR_TCTL = TIMER_ADDR_TCTL
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      ABUS,
  inout  wire  [DBITS-1:0] DBUS,
  input  logic             we,
  output logic             irq
);

  logic [DBITS-1:0] tcnt_q, tcnt_d;
  logic [DBITS-1:0] tlim_q, tlim_d;
  logic             ready_q, ready_d;
  logic             ovr_q, ovr_d;
  logic             ie_q, ie_d;

  logic             tick;
  logic             wr_tcnt, wr_tlim, wr_tctl;
  logic             ready_clr;
  logic             rd_sel;
  logic [DBITS-1:0] rd_data;

  assign wr_tcnt = we && (ABUS == ADDR_TCNT);
  assign wr_tlim = we && (ABUS == ADDR_TLIM);
  assign wr_tctl = we && (ABUS == ADDR_TCTL);

  timer_device_tick_gen #(
    .PRESCALE(PRESCALE)
  ) u_tick_gen (
    .clk_i (clk),
    .rst_i (rst),
    .clr_i (wr_tcnt | wr_tlim),
    .tick_o(tick)
  );

  assign ready_clr = wr_tctl && !DBUS[TCTL_READY_BIT];

  always_comb begin
    tcnt_d  = tcnt_q;
    tlim_d  = tlim_q;
    ready_d = ready_q;
    ovr_d   = ovr_q;
    ie_d    = ie_q;

    if (wr_tctl) begin
      ie_d = DBUS[TCTL_IE_BIT];
      if (!DBUS[TCTL_OVR_BIT]) ovr_d = 1'b0;
      if (ready_clr) ready_d = 1'b0;
    end

    // Counter writes discard a coincident tick; flag sets below override clears.
    if (wr_tcnt) begin
      tcnt_d = DBUS;
    end else if (wr_tlim) begin
      tlim_d = DBUS;
      tcnt_d = '0;
    end else if (tick) begin
      if (tlim_q == '0) begin
        tcnt_d = tcnt_q + DBITS'(1);
      end else if (tcnt_q >= tlim_q - DBITS'(1)) begin
        tcnt_d  = '0;
        ready_d = 1'b1;
        if (ready_q && !ready_clr) ovr_d = 1'b1;
      end else begin
        tcnt_d = tcnt_q + DBITS'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tcnt_q  <= '0;
      tlim_q  <= '0;
      ready_q <= 1'b0;
      ovr_q   <= 1'b0;
      ie_q    <= 1'b0;
    end else begin
      tcnt_q  <= tcnt_d;
      tlim_q  <= tlim_d;
      ready_q <= ready_d;
      ovr_q   <= ovr_d;
      ie_q    <= ie_d;
    end
  end

  always_comb begin
    rd_sel  = 1'b0;
    rd_data = '0;
    if (!we) begin
      case (ABUS)
        ADDR_TCNT: begin
          rd_sel  = 1'b1;
          rd_data = tcnt_q;
        end
        ADDR_TLIM: begin
          rd_sel  = 1'b1;
          rd_data = tlim_q;
        end
        ADDR_TCTL: begin
          rd_sel                  = 1'b1;
          rd_data[TCTL_READY_BIT] = ready_q;
          rd_data[TCTL_OVR_BIT]   = ovr_q;
          rd_data[TCTL_IE_BIT]    = ie_q;
        end
        default: ;
      endcase
    end
  end

  assign DBUS = rd_sel ? rd_data : {DBITS{1'bz}};
  assign irq  = ie_q & ready_q;

endmodule

// File: tb/tb_timer_device.sv
// Bench for timer_device: directed vector table, two cycle-exact corner
// sequences, then random bus traffic checked against a behavioural model.
module tb_timer_device;

  localparam int unsigned P = 4;
  localparam logic [31:0] A_TCNT = 32'hF000_0020;
  localparam logic [31:0] A_TLIM = 32'hF000_0024;
  localparam logic [31:0] A_TCTL = 32'hF000_0120;
  localparam logic [31:0] A_UNM  = 32'hF000_0000;
  localparam logic [31:0] FLOAT  = 32'hFFFF_FFFF;  // pulled-up bus, nobody driving

  localparam int OP_WR  = 0;
  localparam int OP_RUN = 1;
  localparam int OP_RD  = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] ABUS = A_UNM;
  logic        we = 1'b0;
  logic [31:0] tb_dat = '0;
  logic        tb_drv = 1'b0;
  logic        irq;
  tri1  [31:0] DBUS;

  assign DBUS = tb_drv ? tb_dat : {32{1'bz}};

  timer_device #(
    .PRESCALE(P)
  ) dut (
    .clk (clk),
    .rst (rst),
    .ABUS(ABUS),
    .DBUS(DBUS),
    .we  (we),
    .irq (irq)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %08h, expected %08h", name, act, exp);
  endtask

  // One bus cycle: drive just after posedge, sample at negedge, end after next posedge.
  task automatic cycle(input logic r, input logic [31:0] a, input logic w, input logic [31:0] d,
                       output logic [31:0] bus, output logic irq_s);
    rst = r; ABUS = a; we = w; tb_dat = d; tb_drv = w;
    @(negedge clk);
    bus = DBUS;
    irq_s = irq;
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    logic [31:0] b;
    logic        i;
    cycle(1'b0, a, 1'b1, d, b, i);
  endtask

  task automatic run(input int n);
    logic [31:0] b;
    logic        i;
    for (int k = 0; k < n; k++) cycle(1'b0, A_UNM, 1'b0, '0, b, i);
  endtask

  task automatic rd(input string name, input logic [31:0] a, input logic [31:0] exp,
                    input logic exp_irq);
    logic [31:0] b;
    logic        i;
    cycle(1'b0, a, 1'b0, '0, b, i);
    check(name, b, exp);
    check({name, "_irq"}, {31'b0, i}, {31'b0, exp_irq});
  endtask

  // ---------------- behavioural reference model ----------------
  logic [31:0] m_cnt, m_lim;
  logic        m_ready, m_ovr, m_ie;
  int unsigned m_since;  // cycles since the millisecond phase last restarted

  task automatic model_reset();
    m_cnt = '0; m_lim = '0; m_ready = 1'b0; m_ovr = 1'b0; m_ie = 1'b0; m_since = 0;
  endtask

  function automatic logic [31:0] model_read(input logic [31:0] a);
    if (a == A_TCNT) return m_cnt;
    if (a == A_TLIM) return m_lim;
    if (a == A_TCTL) return (m_ie ? 32'h100 : 32'h0) | (m_ovr ? 32'h4 : 32'h0) |
                            (m_ready ? 32'h1 : 32'h0);
    return FLOAT;
  endfunction

  task automatic model_step(input logic [31:0] a, input logic w, input logic [31:0] d);
    bit tick, clr_r, ctl_w;
    tick  = (m_since % P) == P - 1;
    ctl_w = w && (a == A_TCTL);
    clr_r = ctl_w && !d[0];
    m_since++;
    if (w && a == A_TCNT) begin
      m_cnt = d;
      m_since = 0;
    end else if (w && a == A_TLIM) begin
      m_lim = d;
      m_cnt = '0;
      m_since = 0;
    end else begin
      if (ctl_w) begin
        m_ie = d[8];
        if (!d[2]) m_ovr = 1'b0;
      end
      if (clr_r) m_ready = 1'b0;
      if (tick) begin
        if (m_lim != 0 && longint'(m_cnt) + 1 >= longint'(m_lim)) begin
          if (m_ready) m_ovr = 1'b1;  // m_ready already reflects this cycle's clear
          m_ready = 1'b1;
          m_cnt = '0;
        end else begin
          m_cnt = m_cnt + 32'd1;
        end
      end
    end
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    int          op;
    logic [31:0] addr;
    logic [31:0] data;  // write data, run length, or expected read value
    logic        exp_irq;
    string       name;
  } vec_t;

  vec_t vq[$];

  task automatic add(input int op, input logic [31:0] a, input logic [31:0] d, input logic ei,
                     input string nm);
    vec_t v;
    v.op = op; v.addr = a; v.data = d; v.exp_irq = ei; v.name = nm;
    vq.push_back(v);
  endtask

  initial begin
    logic [31:0] b, a, d;
    logic        i, w, r;
    int          sel;

    add(OP_RD,  A_TCTL, 32'h0,        1'b0, "rst_tctl");
    add(OP_RD,  A_TCNT, 32'h0,        1'b0, "rst_tcnt");
    add(OP_RD,  A_TLIM, 32'h0,        1'b0, "rst_tlim");
    add(OP_RD,  A_UNM,  FLOAT,        1'b0, "rst_bus_released");
    add(OP_WR,  A_TCNT, 32'h0,        1'b0, "");
    add(OP_RUN, '0,     32'd40,       1'b0, "");
    add(OP_RD,  A_TCNT, 32'd10,       1'b0, "free_run_40");
    add(OP_WR,  A_TCNT, 32'hFFFFFFFF, 1'b0, "");
    add(OP_RUN, '0,     32'd4,        1'b0, "");
    add(OP_RD,  A_TCNT, 32'h0,        1'b0, "wrap_32bit");
    add(OP_RD,  A_TCTL, 32'h0,        1'b0, "no_ready_free_run");
    add(OP_WR,  A_TLIM, 32'd3,        1'b0, "");
    add(OP_RUN, '0,     32'd4,        1'b0, "");
    add(OP_RD,  A_TCNT, 32'd1,        1'b0, "lim_seq_1");
    add(OP_RUN, '0,     32'd3,        1'b0, "");
    add(OP_RD,  A_TCNT, 32'd2,        1'b0, "lim_seq_2");
    add(OP_RUN, '0,     32'd3,        1'b0, "");
    add(OP_RD,  A_TCNT, 32'd0,        1'b0, "lim_seq_0");
    add(OP_RD,  A_TCTL, 32'h1,        1'b0, "ready_set");
    add(OP_RUN, '0,     32'd12,       1'b0, "");
    add(OP_RD,  A_TCTL, 32'h5,        1'b0, "ovr_set");
    add(OP_RD,  A_TCNT, 32'h0,        1'b0, "cnt_after_ovr");
    add(OP_WR,  A_TCTL, 32'h100,      1'b0, "");
    add(OP_RD,  A_TCTL, 32'h100,      1'b0, "ie_set_flags_clr");
    add(OP_RUN, '0,     32'd6,        1'b0, "");
    add(OP_RD,  A_TCTL, 32'h101,      1'b1, "irq_on");
    add(OP_WR,  A_TCTL, 32'h100,      1'b0, "");
    add(OP_RD,  A_TCTL, 32'h100,      1'b0, "irq_off_ie_kept");
    add(OP_RD,  A_TLIM, 32'd3,        1'b0, "tlim_readback");

    cycle(1'b1, A_UNM, 1'b0, '0, b, i);
    cycle(1'b1, A_UNM, 1'b0, '0, b, i);

    foreach (vq[k]) begin
      unique case (vq[k].op)
        OP_WR:   wr(vq[k].addr, vq[k].data);
        OP_RUN:  run(int'(vq[k].data));
        default: rd(vq[k].name, vq[k].addr, vq[k].data, vq[k].exp_irq);
      endcase
    end

    // Clearing READY on the very cycle a wrap sets it: set wins, OVR stays 0.
    wr(A_TLIM, 32'd2);
    run(8);
    run(4);
    run(3);
    wr(A_TCTL, 32'h0);
    rd("wrap_vs_clear", A_TCTL, 32'h1, 1'b0);
    rd("wrap_vs_clear_cnt", A_TCNT, 32'h0, 1'b0);

    // TCNT write on a tick cycle drops the tick and restarts the phase.
    wr(A_TLIM, 32'd0);
    run(3);
    wr(A_TCNT, 32'd7);
    rd("tcnt_wr_on_tick", A_TCNT, 32'd7, 1'b0);
    run(2);
    rd("tcnt_hold_3clk", A_TCNT, 32'd7, 1'b0);
    rd("tcnt_inc_4clk", A_TCNT, 32'd8, 1'b0);

    // Random traffic against the model, with occasional mid-count resets.
    cycle(1'b1, A_UNM, 1'b0, '0, b, i);
    model_reset();
    for (int n = 0; n < 600; n++) begin
      sel = int'($urandom_range(0, 3));
      a = (sel == 0) ? A_TCNT : (sel == 1) ? A_TLIM : (sel == 2) ? A_TCTL :
          (($urandom_range(0, 1) == 0) ? 32'hF000_0028 : 32'hF000_0124);
      if ($urandom_range(0, 2) == 0) a = A_UNM;
      w = ($urandom_range(0, 5) == 0);
      r = ($urandom_range(0, 149) == 0);
      if (r) w = 1'b0;
      if (a == A_TCNT) d = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 5))
                                                       : 32'hFFFFFFFF - 32'($urandom_range(0, 3));
      else if (a == A_TLIM) d = 32'($urandom_range(0, 5));
      else d = $urandom;
      cycle(r, a, w, d, b, i);
      check($sformatf("rand_irq@%0d", n), {31'b0, i}, {31'b0, m_ready & m_ie});
      if (!w) check($sformatf("rand_dbus@%0d a=%08h", n, a), b, model_read(a));
      if (r) model_reset();
      else model_step(a, w, d);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
